pixel_fetch: RTL and testbench

- Downstream stage of the horizontal and vertical timing generators.
- Consumes the hBright, vBright, hSync and vSync they produce, converts the display window into pixel column/row coordinates, and issues framebuffer reads.
- Drives registered 8-bit RGB (3-3-2) plus delayed syncs to the VGA pins, aligned to the framebuffer read latency.

---
 rtl/pixel_fetch.sv | 104 ++++++++++
 tb/tb_pixel_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch.sv
// pixel_fetch: turns timing-generator windows into pixel coordinates, issues framebuffer reads
// and drives latency-aligned RGB 3-3-2 plus delayed syncs.
module pixel_fetch #(
    parameter int CLKS_PER_PIXEL = 4,
    parameter int H_PIXELS       = 640,
    parameter int V_LINES        = 480,
    parameter int ADDR_W         = 19,
    parameter int RD_LAT         = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              hBright,
    input  logic              vBright,
    input  logic              hSync,
    input  logic              vSync,
    input  logic [7:0]        fb_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    output logic [9:0]        pixX,
    output logic [8:0]        pixY,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              hSyncOut,
    output logic              vSyncOut
);
    localparam int DW = $clog2(CLKS_PER_PIXEL);

    logic [DW-1:0]     div_q, div_d;
    logic              hb_q, armed_q, fetch_en_q, fetch_en_d, fb_rd_q, fb_rd_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d, line_base_q, line_base_d;
    logic [9:0]        pix_x_q, pix_x_d;
    logic [8:0]        pix_y_q, pix_y_d;
    logic [RD_LAT:0]   bright_q, hs_q, vs_q;
    logic [RD_LAT-1:0] rd_q;
    logic [7:0]        hold_q, hold_d, rgb_q, rgb_d;
    logic              active, line_start, line_end, wrap, last_col, row_step;

    // armed_q blocks a false line start when reset is released in the middle of a line
    assign active     = hBright & vBright;
    assign line_start = active & ~hb_q & armed_q;
    assign line_end   = ~hBright & hb_q & vBright;
    assign wrap       = div_q == DW'(CLKS_PER_PIXEL - 1);
    assign last_col   = pix_x_q == 10'(H_PIXELS - 1);
    assign row_step   = line_end & (pix_y_q != 9'(V_LINES - 1));

    always_comb begin
        div_d       = (!active || wrap) ? '0 : div_q + DW'(1);
        fb_rd_d     = active & (div_q == '0) & (fetch_en_q | line_start);
        fetch_en_d  = (!hBright || (fb_rd_d && last_col)) ? 1'b0 : line_start ? 1'b1 : fetch_en_q;
        fb_addr_d   = fb_rd_d ? line_base_q + ADDR_W'(pix_x_q) : fb_addr_q;
        pix_x_d     = !active ? '0 : (wrap && !last_col) ? pix_x_q + 10'd1 : pix_x_q;
        pix_y_d     = !vBright ? '0 : row_step ? pix_y_q + 9'd1 : pix_y_q;
        line_base_d = !vBright ? '0 : row_step ? line_base_q + ADDR_W'(H_PIXELS) : line_base_q;
        hold_d      = rd_q[RD_LAT-1] ? fb_data : hold_q;
        rgb_d       = bright_q[RD_LAT] ? hold_d : 8'd0;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            div_q       <= '0;
            hb_q        <= 1'b0;
            armed_q     <= 1'b0;
            fetch_en_q  <= 1'b0;
            fb_rd_q     <= 1'b0;
            fb_addr_q   <= '0;
            line_base_q <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            bright_q    <= '0;
            hs_q        <= '1;
            vs_q        <= '1;
            rd_q        <= '0;
            hold_q      <= '0;
            rgb_q       <= '0;
        end else begin
            div_q       <= div_d;
            hb_q        <= hBright;
            armed_q     <= armed_q | ~hBright;
            fetch_en_q  <= fetch_en_d;
            fb_rd_q     <= fb_rd_d;
            fb_addr_q   <= fb_addr_d;
            line_base_q <= line_base_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            bright_q    <= {bright_q[RD_LAT-1:0], active};
            hs_q        <= {hs_q[RD_LAT-1:0], hSync};
            vs_q        <= {vs_q[RD_LAT-1:0], vSync};
            rd_q        <= RD_LAT'({rd_q, fb_rd_q});
            hold_q      <= hold_d;
            rgb_q       <= rgb_d;
        end
    end

    assign fb_addr  = fb_addr_q;
    assign fb_rd    = fb_rd_q;
    assign pixX     = pix_x_q;
    assign pixY     = pix_y_q;
    assign red      = rgb_q[7:5];
    assign green    = rgb_q[4:2];
    assign blue     = rgb_q[1:0];
    assign hSyncOut = hs_q[RD_LAT];
    assign vSyncOut = vs_q[RD_LAT];
endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: cycle-indexed scoreboard for pixel_fetch; stimulus pushes expected reads and
// pixels, a negedge monitor pops them and checks syncs/RGB against the recorded input history.
module tb_pixel_fetch;
    logic        CLK = 0, CLR = 1, hBright = 0, vBright = 0, hSync = 1, vSync = 1;
    logic [7:0]  fb_data = 0;
    logic [18:0] fb_addr;
    logic        fb_rd, hSyncOut, vSyncOut;
    logic [9:0]  pixX;
    logic [8:0]  pixY;
    logic [2:0]  red, green;
    logic [1:0]  blue;

    pixel_fetch dut (
        .CLK(CLK), .CLR(CLR), .hBright(hBright), .vBright(vBright), .hSync(hSync), .vSync(vSync),
        .fb_data(fb_data), .fb_addr(fb_addr), .fb_rd(fb_rd), .pixX(pixX), .pixY(pixY),
        .red(red), .green(green), .blue(blue), .hSyncOut(hSyncOut), .vSyncOut(vSyncOut)
    );

    always #5 CLK = ~CLK;

    typedef struct {int cyc; int addr; int col; int row;} rd_t;
    typedef struct {int cyc; logic [7:0] val;} px_t;

    int total = 0, bad = 0, cyc = 0, row = 0;
    rd_t rq[$];
    px_t pq[$];
    bit act_h[131072], hs_h[131072], vs_h[131072], rs_h[131072];
    logic [7:0] cur = 0;
    int  pend_a[2];
    bit  pend_v[2];

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] mem(input int a);
        return 8'(a * 37) + 8'hE3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Framebuffer: data for a read seen in cycle t is presented during cycle t+2, garbage otherwise
    initial forever begin
        @(negedge CLK);
        fb_data   = pend_v[1] ? mem(pend_a[1]) : 8'($urandom);
        pend_v[1] = pend_v[0];
        pend_a[1] = pend_a[0];
        pend_v[0] = fb_rd;
        pend_a[0] = int'(fb_addr);
    end

    initial forever begin
        bit exp_rd, rw;
        rd_t e;
        @(negedge CLK);
        act_h[cyc] = hBright & vBright;
        hs_h[cyc]  = hSync;
        vs_h[cyc]  = vSync;
        rs_h[cyc]  = CLR;
        if (CLR) begin
            rq.delete();
            pq.delete();
            cur = 0;
        end
        if (pq.size() > 0 && pq[0].cyc == cyc) cur = pq.pop_front().val;
        exp_rd = rq.size() > 0 && rq[0].cyc == cyc;
        if (fb_rd || exp_rd) begin
            chk("rd_strobe", fb_rd, exp_rd);
            if (exp_rd) begin
                e = rq.pop_front();
                chk("rd_addr", fb_addr, e.addr);
                chk("rd_col", pixX, e.col);
                chk("rd_row", pixY, e.row);
            end
        end
        if (cyc >= 5) begin
            rw = rs_h[cyc] | rs_h[cyc-1] | rs_h[cyc-2] | rs_h[cyc-3];
            chk("hsync_out", hSyncOut, rw ? 1'b1 : hs_h[cyc-3]);
            chk("vsync_out", vSyncOut, rw ? 1'b1 : vs_h[cyc-3]);
            chk("rgb", {red, green, blue}, (rw || rs_h[cyc-4] || !act_h[cyc-4]) ? 8'd0 : cur);
        end
    end

    task automatic push_reads(input int s, input int n);
        rd_t r;
        px_t p;
        for (int k = 0; k < n; k++) begin
            r.cyc = s + 1 + 4 * k; r.addr = row * 640 + k; r.col = k; r.row = row;
            rq.push_back(r);
            p.cyc = s + 4 + 4 * k; p.val = mem(r.addr);
            pq.push_back(p);
        end
    endtask

    // hBright high for hi cycles then low for lo; hSync low for the first hs_lo blank cycles
    task automatic line(input int hi, input int lo, input int hs_lo, input bit vfall);
        int n;
        n = (hi + 3) / 4;
        push_reads(cyc, n > 640 ? 640 : n);
        hBright = 1;
        step(hi);
        chk("pixX_end", pixX, (hi / 4 > 639) ? 639 : hi / 4);
        chk("pixY_line", pixY, row);
        hBright = 0;
        if (vfall) begin
            vBright = 0;
            row = 0;
        end else if (vBright) row = (row < 479) ? row + 1 : 479;
        if (hs_lo > 0) begin
            hSync = 0;
            step(hs_lo);
            hSync = 1;
        end
        step(lo - hs_lo);
    endtask

    initial begin
        int s;
        step(2);
        chk("rst_rd", fb_rd, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_pixX", pixX, 0);
        chk("rst_pixY", pixY, 0);
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_hs", hSyncOut, 1);
        chk("rst_vs", vSyncOut, 1);
        CLR = 0;
        step(4);
        // full line capped at 640 reads, then two shorter lines and vBright drop
        vBright = 1;
        step(3);
        line(2600, 20, 10, 0);
        line(200, 10, 3, 0);
        line(100, 10, 3, 0);
        vBright = 0;
        row = 0;
        step(2);
        chk("pixY_vblank", pixY, 0);
        // long sync pulses
        hSync = 0; step(377); hSync = 1; step(6);
        vSync = 0; step(377); vSync = 1; step(6);
        // randomized frames
        for (int f = 0; f < 4; f++) begin
            vBright = 1;
            step(2);
            for (int l = 0; l < int'($urandom_range(3, 10)); l++)
                line(int'($urandom_range(1, 300)), int'($urandom_range(3, 20)), int'($urandom_range(0, 2)), 0);
            if ($urandom % 2 == 1) line(int'($urandom_range(1, 60)), 5, 1, 1);
            vBright = 0;
            row = 0;
            vSync = 0;
            step(int'($urandom_range(1, 30)));
            vSync = 1;
            step(4);
        end
        // reset in the middle of a line, on a read cycle at column 100
        vBright = 1;
        step(3);
        s = cyc;
        push_reads(s, 640);
        hBright = 1;
        step(395);
        hSync = 0;
        step(6);
        chk("mid_pixX", pixX, 100);
        chk("mid_rd", fb_rd, 1);
        CLR = 1;
        row = 0;
        #1;
        chk("clr_rd", fb_rd, 0);
        chk("clr_pixX", pixX, 0);
        chk("clr_rgb", {red, green, blue}, 0);
        chk("clr_hs", hSyncOut, 1);
        step(2);
        CLR = 0;
        hSync = 1;
        step(40);
        hBright = 0;
        vBright = 0;
        step(4);
        vBright = 1;
        step(3);
        line(40, 10, 2, 0);
        vBright = 0;
        row = 0;
        step(3);
        // full 480-line frame ending with hBright and vBright falling together
        vBright = 1;
        step(3);
        for (int l = 0; l < 479; l++) line(4, 2, 1, 0);
        line(4, 3, 1, 1);
        chk("vfall_pixY", pixY, 0);
        vBright = 1;
        step(3);
        line(8, 4, 1, 0);
        step(10);
        chk("rq_left", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
